// File: rtl/rx_flow_controller_pkg.sv
// Shared types and constants for the UART receive flow controller.
// Contents: FSM state enum, RX FIFO entry layout ({ferr, perr, data}) helpers.
package rx_flow_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCEPT   = 2'd1,
        ST_THROTTLE = 2'd2,
        ST_FLUSH    = 2'd3
    } rx_flow_state_t;

    // Flag bits stored above the character in each FIFO entry
    localparam int unsigned RX_FLAG_W = 2;
    localparam int unsigned PERR_OFS  = 0;  // offset above DATA_WIDTH
    localparam int unsigned FERR_OFS  = 1;  // offset above DATA_WIDTH

    function automatic int unsigned rx_entry_w(input int unsigned data_w);
        return data_w + RX_FLAG_W;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with registered level/empty/full and a flush input.
// Ports: clear_i empties the FIFO (wins over push/pop); push_i/pop_i requests;
//  wdata_i entry in; head_c_o oldest entry (combinational); level_o occupancy;
//  level_nxt_c_o occupancy after this cycle; empty_o/full_o status;
//  pop_ok_c_o pop accepted this cycle.
module rx_sync_fifo #(
    parameter  int unsigned WIDTH = 10,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_c_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] level_nxt_c_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             pop_ok_c_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_q, full_q;
    logic             wr_en, rd_en;

    // A push into a full FIFO only succeeds when a pop frees a slot the same cycle
    assign rd_en = pop_i && !empty_q && !clear_i;
    assign wr_en = push_i && (!full_q || rd_en) && !clear_i;

    // Pointer and level next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en && !rd_en) begin
                level_d = level_q + LVL_W'(1);
            end else if (rd_en && !wr_en) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == LVL_W'(DEPTH));
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_c_o      = mem_q[rd_ptr_q];
    assign level_o       = level_q;
    assign level_nxt_c_o = level_d;
    assign empty_o       = empty_q;
    assign full_o        = full_q;
    assign pop_ok_c_o    = rd_en;

endmodule

// File: rtl/rx_flow_controller.sv
// UART receive-path sequencer: receiver enable, RX FIFO with error flags,
// RTS flow control with hi/lo hysteresis, sticky overrun and level interrupt.
// Ports: rx_enable_i/flush_i control; hi/lo/irq_thresh_i thresholds; ovr_clr_i
//  clears overrun; rx_data_i/rx_valid_i/parity_err_i/frame_err_i from receiver;
//  rd_req_i pops; rx_en_o, rts_no (active-low), rd_* popped character, level_o,
//  empty_o/full_o, overrun_o, irq_o. All outputs registered.
module rx_flow_controller
    import rx_flow_controller_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_enable_i,
    input  logic                  flush_i,
    input  logic [LVL_W-1:0]      hi_thresh_i,
    input  logic [LVL_W-1:0]      lo_thresh_i,
    input  logic [LVL_W-1:0]      irq_thresh_i,
    input  logic                  ovr_clr_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  parity_err_i,
    input  logic                  frame_err_i,
    input  logic                  rd_req_i,
    output logic                  rx_en_o,
    output logic                  rts_no,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_perr_o,
    output logic                  rd_ferr_o,
    output logic                  rd_valid_o,
    output logic [LVL_W-1:0]      level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overrun_o,
    output logic                  irq_o
);

    localparam int unsigned RX_ENTRY_W = rx_entry_w(DATA_WIDTH);

    rx_flow_state_t state_q, state_d;

    logic                  rx_en_q, rx_en_d;
    logic                  rts_n_q, rts_n_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_perr_q, rd_perr_d;
    logic                  rd_ferr_q, rd_ferr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  irq_q, irq_d;

    logic                  push_req, pop_req, pop_ok, ovr_set;
    logic [RX_ENTRY_W-1:0] wr_entry, head;
    logic [LVL_W-1:0]      level_nxt, hi_eff;
    logic                  fifo_full;

    // Flush discards any coincident push or pop
    assign push_req = rx_valid_i && !flush_i &&
                      ((state_q == ST_ACCEPT) || (state_q == ST_THROTTLE));
    assign pop_req  = rd_req_i && !flush_i && (state_q != ST_FLUSH);
    assign wr_entry = {frame_err_i, parity_err_i, rx_data_i};

    // A full FIFO with a pop in the same cycle still accepts the push
    assign ovr_set  = push_req && fifo_full && !pop_req;

    assign hi_eff   = (hi_thresh_i == '0) ? LVL_W'(FIFO_DEPTH) : hi_thresh_i;

    rx_sync_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (flush_i),
        .push_i        (push_req),
        .pop_i         (pop_req),
        .wdata_i       (wr_entry),
        .head_c_o      (head),
        .level_o       (level_o),
        .level_nxt_c_o (level_nxt),
        .empty_o       (empty_o),
        .full_o        (fifo_full),
        .pop_ok_c_o    (pop_ok)
    );

    assign full_o = fifo_full;

    // Next state and registered-output decode; thresholds compare the post-update level
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_FLUSH;
        end else if (!rx_enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_ACCEPT;
                ST_ACCEPT:   if (level_nxt >= hi_eff)      state_d = ST_THROTTLE;
                ST_THROTTLE: if (level_nxt <= lo_thresh_i) state_d = ST_ACCEPT;
                ST_FLUSH:    state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
        rx_en_d = (state_d == ST_ACCEPT) || (state_d == ST_THROTTLE);
        rts_n_d = (state_d != ST_ACCEPT);
    end

    // Read-port, overrun and interrupt next-state
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_perr_d  = rd_perr_q;
        rd_ferr_d  = rd_ferr_q;
        rd_valid_d = pop_ok;
        if (pop_ok) begin
            rd_data_d = head[DATA_WIDTH-1:0];
            rd_perr_d = head[DATA_WIDTH + PERR_OFS];
            rd_ferr_d = head[DATA_WIDTH + FERR_OFS];
        end
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end
        irq_d = ((irq_thresh_i != '0) && (level_nxt >= irq_thresh_i)) || overrun_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rx_en_q    <= 1'b0;
            rts_n_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_perr_q  <= 1'b0;
            rd_ferr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_en_q    <= rx_en_d;
            rts_n_q    <= rts_n_d;
            rd_data_q  <= rd_data_d;
            rd_perr_q  <= rd_perr_d;
            rd_ferr_q  <= rd_ferr_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
        end
    end

    assign rx_en_o    = rx_en_q;
    assign rts_no     = rts_n_q;
    assign rd_data_o  = rd_data_q;
    assign rd_perr_o  = rd_perr_q;
    assign rd_ferr_o  = rd_ferr_q;
    assign rd_valid_o = rd_valid_q;
    assign overrun_o  = overrun_q;
    assign irq_o      = irq_q;

endmodule
